// File: rtl/line_sense_ctrl.sv
// rtl/line_sense_ctrl.sv - line/bumper sensor conditioning and steering classifier
// Raw inputs pass a 2-FF synchroniser and a per-input debounce filter before the FSM.
module line_sense_ctrl #(
  parameter int DEBOUNCE_CYCLES      = 500_000,
  parameter int JUNCTION_HOLD_CYCLES = 25_000_000,
  parameter int LOST_TIMEOUT_CYCLES  = 12_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sensorL,
  input  logic       sensorC,
  input  logic       sensorR,
  input  logic       bumper,
  input  logic       clearCollision,
  output logic       veerLeft,
  output logic       veerRight,
  output logic       collision,
  output logic       junction,
  output logic       lineLost,
  output logic [2:0] steerState
);

  typedef enum logic [2:0] {
    TRACK    = 3'd0,
    VEER_L   = 3'd1,
    VEER_R   = 3'd2,
    JUNCTION = 3'd3,
    LOST     = 3'd4,
    COLLIDE  = 3'd5
  } state_e;

  localparam logic [19:0] DB_LIMIT  = 20'(DEBOUNCE_CYCLES);
  localparam logic [24:0] HOLD_LAST = 25'(JUNCTION_HOLD_CYCLES - 1);
  localparam logic [23:0] LOST_LAST = 24'(LOST_TIMEOUT_CYCLES - 1);

  // bit 3 = bumper, bits 2:0 = {L, C, R}
  logic [3:0]       raw;
  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  logic [3:0]       filt_q, filt_d;
  logic [3:0][19:0] db_cnt_q, db_cnt_d;

  state_e      state_q, state_d;
  logic        veer_l_q, veer_l_d;
  logic        veer_r_q, veer_r_d;
  logic        collision_q, collision_d;
  logic        junction_q, junction_d;
  logic        line_lost_q, line_lost_d;
  logic [24:0] hold_cnt_q, hold_cnt_d;
  logic [23:0] lost_cnt_q, lost_cnt_d;

  logic [2:0]  pattern;
  logic        bump_f;
  logic        evaluate;

  assign raw     = {bumper, sensorL, sensorC, sensorR};
  assign pattern = filt_q[2:0];
  assign bump_f  = filt_q[3];

  always_comb begin
    sync1_d  = raw;
    sync2_d  = sync1_q;
    filt_d   = filt_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (sync2_q[i] == filt_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LIMIT) begin
        filt_d[i]   = sync2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + 20'd1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    veer_l_d    = veer_l_q;
    veer_r_d    = veer_r_q;
    collision_d = collision_q;
    junction_d  = 1'b0;
    line_lost_d = line_lost_q;
    hold_cnt_d  = hold_cnt_q;
    lost_cnt_d  = lost_cnt_q;
    evaluate    = 1'b0;

    if (state_q == COLLIDE) begin
      if (clearCollision && !bump_f) begin
        state_d     = TRACK;
        collision_d = 1'b0;
      end
    end else if (bump_f) begin
      state_d     = COLLIDE;
      collision_d = 1'b1;
      veer_l_d    = 1'b0;
      veer_r_d    = 1'b0;
      line_lost_d = 1'b0;
      hold_cnt_d  = '0;
      lost_cnt_d  = '0;
    end else begin
      case (state_q)
        JUNCTION: begin
          if (hold_cnt_q == HOLD_LAST) evaluate = 1'b1;
          else hold_cnt_d = hold_cnt_q + 25'd1;
        end
        LOST: begin
          if (pattern != 3'b000) begin
            evaluate = 1'b1;
          end else if (!line_lost_q) begin
            lost_cnt_d = lost_cnt_q + 24'd1;
            if (lost_cnt_q == LOST_LAST) begin
              line_lost_d = 1'b1;
              veer_l_d    = 1'b0;
              veer_r_d    = 1'b0;
            end
          end
        end
        TRACK, VEER_L, VEER_R: evaluate = 1'b1;
        default: begin
          state_d  = TRACK;
          veer_l_d = 1'b0;
          veer_r_d = 1'b0;
        end
      endcase
    end

    if (evaluate) begin
      hold_cnt_d  = '0;
      lost_cnt_d  = '0;
      line_lost_d = 1'b0;
      case (pattern)
        3'b010, 3'b101: begin
          state_d  = TRACK;
          veer_l_d = 1'b0;
          veer_r_d = 1'b0;
        end
        3'b100, 3'b110: begin
          state_d  = VEER_L;
          veer_l_d = 1'b1;
          veer_r_d = 1'b0;
        end
        3'b001, 3'b011: begin
          state_d  = VEER_R;
          veer_l_d = 1'b0;
          veer_r_d = 1'b1;
        end
        3'b111: begin
          state_d    = JUNCTION;
          junction_d = 1'b1;
          veer_l_d   = 1'b0;
          veer_r_d   = 1'b0;
        end
        // Veer outputs are kept so the drive keeps turning back toward the line.
        default: state_d = LOST;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      filt_q      <= '0;
      db_cnt_q    <= '0;
      state_q     <= TRACK;
      veer_l_q    <= 1'b0;
      veer_r_q    <= 1'b0;
      collision_q <= 1'b0;
      junction_q  <= 1'b0;
      line_lost_q <= 1'b0;
      hold_cnt_q  <= '0;
      lost_cnt_q  <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      filt_q      <= filt_d;
      db_cnt_q    <= db_cnt_d;
      state_q     <= state_d;
      veer_l_q    <= veer_l_d;
      veer_r_q    <= veer_r_d;
      collision_q <= collision_d;
      junction_q  <= junction_d;
      line_lost_q <= line_lost_d;
      hold_cnt_q  <= hold_cnt_d;
      lost_cnt_q  <= lost_cnt_d;
    end
  end

  assign veerLeft   = veer_l_q;
  assign veerRight  = veer_r_q;
  assign collision  = collision_q;
  assign junction   = junction_q;
  assign lineLost   = line_lost_q;
  assign steerState = state_q;

endmodule
